// File: rtl/needs_pkg.sv
// needs_pkg: life-cycle state type, need index names and default thresholds for needs_monitor
package needs_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_NEEDY = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam int NEED_HUNGER  = 0;
    localparam int NEED_HAPPY   = 1;
    localparam int NEED_HEALTH  = 2;
    localparam int NEED_HYGIENE = 3;
    localparam int NEED_ENERGY  = 4;

    localparam int DEF_NUM_NEEDS    = 5;
    localparam int DEF_LEVEL_W      = 4;
    localparam int DEF_WARN_LEVEL   = 12;
    localparam int DEF_DEAD_LEVEL   = 15;
    localparam int DEF_HOLD_SAMPLES = 3;
    localparam int DEF_HYST         = 2;

endpackage

// File: rtl/need_channel.sv
// need_channel: one need's persistence counter, sticky flag and post-acknowledge mask
module need_channel
    import needs_pkg::*;
#(
    parameter int LEVEL_W      = DEF_LEVEL_W,
    parameter int WARN_LEVEL   = DEF_WARN_LEVEL,
    parameter int CLR_LEVEL    = DEF_WARN_LEVEL,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic               freeze,
    input  logic               clear,
    input  logic               ack,
    input  logic [LEVEL_W-1:0] level,
    output logic               flag,
    output logic               flag_next
);
    localparam int CW = $clog2(HOLD_SAMPLES + 1);
    localparam logic [LEVEL_W-1:0] WARN = LEVEL_W'(WARN_LEVEL);
    localparam logic [LEVEL_W-1:0] CLR  = LEVEL_W'(CLR_LEVEL);
    localparam logic [CW-1:0] HOLD = CW'(HOLD_SAMPLES);

    logic [CW-1:0] count, count_next;
    logic          mask, mask_next;

    // clear (revive) beats freeze (dead), which beats ack, which beats a sample
    always_comb begin
        count_next = count;
        flag_next  = flag;
        mask_next  = mask;
        if (clear) begin
            count_next = '0;
            flag_next  = 1'b0;
            mask_next  = 1'b0;
        end else if (!freeze) begin
            if (ack) begin
                count_next = '0;
                flag_next  = 1'b0;
                mask_next  = 1'b1;
            end else if (sample_en) begin
                if (level >= WARN && !mask) begin
                    count_next = (count == HOLD) ? count : count + 1'b1;
                    flag_next  = flag | (count_next == HOLD);
                end else if (level < CLR) begin
                    count_next = '0;
                    flag_next  = 1'b0;
                    mask_next  = 1'b0;
                end else if (level < WARN) begin
                    count_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            flag  <= 1'b0;
            mask  <= 1'b0;
        end else begin
            count <= count_next;
            flag  <= flag_next;
            mask  <= mask_next;
        end
    end

endmodule

// File: rtl/needs_monitor.sv
// needs_monitor: N filtered need channels, alive/needy/dead FSM and urgency encoder
// NEEDS_MONITOR_HYST_EN lowers the clear threshold to WARN_LEVEL-HYST
module needs_monitor
    import needs_pkg::*;
#(
    parameter int NUM_NEEDS    = DEF_NUM_NEEDS,
    parameter int LEVEL_W      = DEF_LEVEL_W,
    parameter int WARN_LEVEL   = DEF_WARN_LEVEL,
    parameter int DEAD_LEVEL   = DEF_DEAD_LEVEL,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES,
    parameter int HYST         = DEF_HYST
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_en,
    input  logic [NUM_NEEDS*LEVEL_W-1:0] levels,
    input  logic [NUM_NEEDS-1:0]         ack,
    input  logic                         revive,
    output logic [NUM_NEEDS-1:0]         need_flags,
    output logic                         urgent_valid,
    output logic [$clog2(NUM_NEEDS)-1:0] urgent_idx,
    output logic                         new_need,
    output state_t                       state,
    output logic                         dead
);
    localparam int IW = $clog2(NUM_NEEDS);
`ifdef NEEDS_MONITOR_HYST_EN
    localparam int CLR_LEVEL = WARN_LEVEL - HYST;
`else
    localparam int CLR_LEVEL = WARN_LEVEL;
`endif

    if (HYST < 0 || HYST >= WARN_LEVEL) begin : g_bad_hyst
        $error("needs_monitor: HYST must satisfy 0 <= HYST < WARN_LEVEL");
    end
    if (DEAD_LEVEL <= WARN_LEVEL) begin : g_bad_dead
        $error("needs_monitor: DEAD_LEVEL must exceed WARN_LEVEL");
    end
    if (HOLD_SAMPLES < 1) begin : g_bad_hold
        $error("needs_monitor: HOLD_SAMPLES must be at least 1");
    end

    state_t               state_next;
    logic [NUM_NEEDS-1:0] flags, flags_next;
    logic                 is_dead, kill;

    assign is_dead = state == ST_DEAD;

    always_comb begin
        kill = 1'b0;
        for (int i = 0; i < NUM_NEEDS; i++)
            if (sample_en && !is_dead && levels[i*LEVEL_W +: LEVEL_W] == LEVEL_W'(DEAD_LEVEL))
                kill = 1'b1;
    end

    // the death cycle freezes channels too, so death overrides a same-cycle ack
    for (genvar c = 0; c < NUM_NEEDS; c++) begin : g_ch
        need_channel #(
            .LEVEL_W     (LEVEL_W),
            .WARN_LEVEL  (WARN_LEVEL),
            .CLR_LEVEL   (CLR_LEVEL),
            .HOLD_SAMPLES(HOLD_SAMPLES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sample_en(sample_en),
            .freeze   (is_dead | kill),
            .clear    (is_dead & revive),
            .ack      (ack[c]),
            .level    (levels[c*LEVEL_W +: LEVEL_W]),
            .flag     (flags[c]),
            .flag_next(flags_next[c])
        );
    end

    always_comb
        state_next = is_dead ? (revive ? ST_ALIVE : ST_DEAD)
                   : kill    ? ST_DEAD
                   : (|flags_next) ? ST_NEEDY : ST_ALIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ALIVE;
            new_need <= 1'b0;
        end else begin
            state    <= state_next;
            new_need <= !is_dead && !kill && |(flags_next & ~flags);
        end
    end

    assign dead         = is_dead;
    assign need_flags   = is_dead ? '1 : flags;
    assign urgent_valid = |flags && !is_dead;

    always_comb begin
        urgent_idx = '0;
        for (int i = NUM_NEEDS - 1; i >= 0; i--)
            if (flags[i] && !is_dead)
                urgent_idx = IW'(i);
    end

endmodule

// File: tb/tb_needs_monitor.sv
// tb_needs_monitor: scoreboarded directed + random stimulus against a rule-level need model
module tb_needs_monitor;
    import needs_pkg::*;

    localparam int N = 5;
    localparam int W = 4;
    localparam int WARN = 12;
    localparam int DEADL = 15;
    localparam int HOLD = 3;
`ifdef NEEDS_MONITOR_HYST_EN
    localparam int CLR = 10;
`else
    localparam int CLR = 12;
`endif

    typedef struct {
        logic [N-1:0] flags;
        logic [1:0]   st;
        logic         nn;
        logic         uv;
        logic [2:0]   idx;
        logic         dd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sample_en = 1'b0;
    logic           revive = 1'b0;
    logic [N*W-1:0] levels = '0;
    logic [N-1:0]   ack = '0;
    logic [N-1:0]   need_flags;
    logic           urgent_valid;
    logic [2:0]     urgent_idx;
    logic           new_need;
    state_t         state;
    logic           dead;

    int    vectors = 0;
    int    miscompares = 0;
    string phase = "reset";
    exp_t  q[$];

    int m_cnt[N];
    bit m_flg[N];
    bit m_msk[N];
    int m_st;

    always #5 clk = ~clk;

    needs_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .levels      (levels),
        .ack         (ack),
        .revive      (revive),
        .need_flags  (need_flags),
        .urgent_valid(urgent_valid),
        .urgent_idx  (urgent_idx),
        .new_need    (new_need),
        .state       (state),
        .dead        (dead)
    );

    function automatic logic [N*W-1:0] mk(int h, int hp, int he, int hy, int en);
        logic [N*W-1:0] v;
        v = '0;
        v[NEED_HUNGER*W +: W]  = W'(h);
        v[NEED_HAPPY*W +: W]   = W'(hp);
        v[NEED_HEALTH*W +: W]  = W'(he);
        v[NEED_HYGIENE*W +: W] = W'(hy);
        v[NEED_ENERGY*W +: W]  = W'(en);
        return v;
    endfunction

    function automatic exp_t expect_now(bit nn);
        exp_t e;
        e.dd = (m_st == 2);
        e.st = 2'(m_st);
        e.nn = nn;
        e.uv = 1'b0;
        e.idx = '0;
        for (int i = 0; i < N; i++) e.flags[i] = e.dd ? 1'b1 : m_flg[i];
        if (!e.dd)
            for (int i = N - 1; i >= 0; i--)
                if (m_flg[i]) begin
                    e.uv = 1'b1;
                    e.idx = 3'(i);
                end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_flg[i] = 0;
            m_msk[i] = 0;
        end
        m_st = 0;
    endtask

    task automatic model_step(bit se, logic [N*W-1:0] lv, logic [N-1:0] ak, bit rv);
        bit nn = 0;
        bit kill = 0;
        bit any = 0;
        int l;
        if (m_st == 2) begin
            if (rv) model_reset();
        end else begin
            for (int i = 0; i < N; i++) if (se && int'(lv[i*W +: W]) == DEADL) kill = 1;
            if (kill) m_st = 2;
            else begin
                for (int i = 0; i < N; i++) begin
                    bit was = m_flg[i];
                    l = int'(lv[i*W +: W]);
                    if (ak[i]) begin
                        m_flg[i] = 0; m_cnt[i] = 0; m_msk[i] = 1;
                    end else if (se) begin
                        if (l >= WARN && !m_msk[i]) begin
                            m_cnt[i] = (m_cnt[i] + 1 > HOLD) ? HOLD : m_cnt[i] + 1;
                            if (m_cnt[i] == HOLD) m_flg[i] = 1;
                        end else if (l < CLR) begin
                            m_flg[i] = 0; m_cnt[i] = 0; m_msk[i] = 0;
                        end else if (l < WARN) m_cnt[i] = 0;
                    end
                    if (m_flg[i] && !was) nn = 1;
                    if (m_flg[i]) any = 1;
                end
                m_st = any ? 1 : 0;
            end
        end
        q.push_back(expect_now(nn));
    endtask

    task automatic step(bit se, logic [N*W-1:0] lv, logic [N-1:0] ak, bit rv);
        @(posedge clk);
        #2;
        sample_en = se;
        levels = lv;
        ack = ak;
        revive = rv;
        model_step(se, lv, ak, rv);
    endtask

    task automatic check(string name, exp_t e);
        logic [1:0] sa;
        sa = state;
        vectors++;
        if (need_flags !== e.flags || sa !== e.st || new_need !== e.nn ||
            urgent_valid !== e.uv || urgent_idx !== e.idx || dead !== e.dd) begin
            miscompares++;
            $display("FAIL %s/%s t=%0t: got flags=%b st=%0d nn=%b uv=%b idx=%0d dead=%b, expected flags=%b st=%0d nn=%b uv=%b idx=%0d dead=%b",
                     name, phase, $time, need_flags, sa, new_need, urgent_valid, urgent_idx, dead,
                     e.flags, e.st, e.nn, e.uv, e.idx, e.dd);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sample_en = 1'b0;
        ack = '0;
        revive = 1'b0;
        #1;
        model_reset();
        check("async_reset", expect_now(0));
        q.push_back(expect_now(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check("scoreboard", q.pop_front());
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset", expect_now(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        phase = "hold";
        repeat (3) step(1, mk(12, 0, 0, 0, 0), '0, 0);
        step(0, mk(12, 0, 0, 0, 0), '0, 0);
        step(1, mk(0, 0, 0, 0, 0), '0, 0);
        repeat (2) step(1, mk(12, 0, 0, 0, 0), '0, 0);
        step(1, mk(11, 0, 0, 0, 0), '0, 0);
        step(1, mk(12, 0, 0, 0, 0), '0, 0);

        phase = "priority";
        step(1, mk(0, 0, 0, 0, 0), '0, 0);
        repeat (3) step(1, mk(0, 0, 0, 13, 14), '0, 0);
        step(0, mk(0, 0, 0, 13, 14), 5'b01000, 0);
        step(1, mk(0, 0, 0, 13, 14), 5'b10000, 0);
        repeat (2) step(1, mk(0, 0, 0, 13, 14), '0, 0);
        step(1, mk(0, 0, 0, 0, 0), '0, 0);

        phase = "mask";
        repeat (3) step(1, mk(13, 0, 0, 0, 0), '0, 0);
        step(0, mk(13, 0, 0, 0, 0), 5'b00001, 0);
        repeat (5) step(1, mk(13, 0, 0, 0, 0), '0, 0);
        step(1, mk(9, 0, 0, 0, 0), '0, 0);
        repeat (3) step(1, mk(12, 0, 0, 0, 0), '0, 0);

        phase = "hyst";
        step(1, mk(11, 0, 0, 0, 0), '0, 0);
        step(1, mk(11, 0, 0, 0, 0), '0, 0);
        step(1, mk(9, 0, 0, 0, 0), '0, 0);

        phase = "death";
        repeat (3) step(1, mk(0, 13, 0, 0, 0), '0, 0);
        step(1, mk(0, 13, 15, 0, 0), 5'b00100, 0);
        step(1, mk(0, 0, 0, 0, 0), 5'b11111, 0);
        step(0, mk(0, 0, 15, 0, 0), '0, 1);
        step(0, mk(0, 0, 15, 0, 0), '0, 1);
        step(1, mk(0, 0, 15, 0, 0), '0, 0);
        step(0, mk(0, 0, 0, 0, 0), '0, 1);
        step(1, mk(0, 0, 0, 0, 0), '0, 0);

        phase = "reset_mid";
        repeat (2) step(1, mk(12, 0, 0, 0, 0), '0, 0);
        async_reset();
        repeat (2) step(1, mk(12, 0, 0, 0, 0), '0, 0);
        step(1, mk(12, 0, 0, 0, 0), '0, 0);
        step(1, mk(0, 0, 0, 0, 0), '0, 0);

        phase = "random";
        for (int n = 0; n < 500; n++) begin
            logic [N*W-1:0] lv;
            logic [N-1:0]   ak;
            for (int i = 0; i < N; i++) begin
                int r = $urandom_range(0, 99);
                lv[i*W +: W] = W'(r == 0 ? 15 : r < 25 ? $urandom_range(0, 9) : $urandom_range(10, 14));
                ak[i] = ($urandom_range(0, 15) == 0);
            end
            step($urandom_range(0, 9) < 7, lv, ak, $urandom_range(0, 5) == 0);
        end
        step(0, mk(0, 0, 0, 0, 0), '0, 0);

        repeat (2) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/needs_monitor.md
# needs_monitor

Parametrised need/status monitor for the pet core. Replaces the fixed five-need status register with N independent need channels. Each channel has:
- a persistence filter,
- a sticky flag with per-need acknowledge,
- masking after acknowledge.

A central life-cycle FSM covers alive, needy and dead, and a priority encoder reports the most urgent need to the display and sound logic. Levels come from the stat counters; the monitor samples them only on the game-tick strobe.

## Interface
- NUM_NEEDS, 5: number of need channels; index 0 has the highest priority.
- LEVEL_W, 4: width of each level; a higher level means a worse need.
- WARN_LEVEL, 12: level at or above which a need qualifies.
- DEAD_LEVEL, 15: level at which the pet dies; must be greater than WARN_LEVEL.
- HOLD_SAMPLES, 3: consecutive qualifying samples before the flag sets; minimum 1.
- HYST, 2: hysteresis depth; used only with the hysteresis macro (see Configuration).
- clk  in  1  the single clock.
- rst_n  in  1  reset, asynchronous and active-low.
- sample_en  in  1  game tick; all channel updates happen only on cycles where it is high.
- levels  in  NUM_NEEDS*LEVEL_W  packed levels; need i occupies bits [i*LEVEL_W +: LEVEL_W].
- ack  in  NUM_NEEDS  one-cycle per-need acknowledge, e.g. fed or cleaned.
- revive  in  1  one-cycle pulse that leaves DEAD.
- need_flags  out  NUM_NEEDS  registered sticky need flags.
- urgent_valid  out  1  at least one flag is set and state is not DEAD.
- urgent_idx  out  $clog2(NUM_NEEDS)  index of the lowest-index set flag; 0 when urgent_valid=0.
- new_need  out  1  one-cycle pulse when any flag rises 0→1.
- state  out  2  FSM state.
- dead  out  1  high when state is DEAD.

## Operation
- Clear threshold CLR:
  - without hysteresis: CLR = WARN_LEVEL;
  - with hysteresis: CLR = WARN_LEVEL-HYST.
- Per channel i, on sample_en, in priority order:
  - level ≥ WARN_LEVEL and mask=0: count saturates upward at HOLD_SAMPLES; flag sets when count reaches HOLD_SAMPLES.
  - level < CLR: count←0, flag←0, mask←0.
  - CLR ≤ level < WARN_LEVEL: count←0; flag and mask hold.
- ack[i] (independent of sample_en): flag←0, count←0, mask←1.
  - While mask=1 the channel cannot re-flag until its level drops below CLR.
  - ack and set in the same cycle: ack wins.
- FSM:
  - ALIVE → NEEDY when any flag will be set next cycle.
  - NEEDY → ALIVE when all flags clear.
  - ALIVE/NEEDY → DEAD on a sample_en cycle where any level == DEAD_LEVEL. Death has priority over ack.
  - DEAD: need_flags forced to all ones; counts and masks frozen; ack and sample_en are ignored.
  - DEAD → ALIVE on revive. Revive clears all flags, counts and masks.
  - revive outside DEAD is ignored.
  - A level still at DEAD_LEVEL re-kills the pet on the next sample_en.
- urgent_idx and urgent_valid are combinational decodes of the registered need_flags, masked by dead.
- Level arithmetic is unsigned LEVEL_W-bit. CLR must not underflow: HYST < WARN_LEVEL, enforced by an elaboration-time check.

## Timing
- Reset values: need_flags=0, counts=0, masks=0, state=ALIVE, dead=0, new_need=0, urgent_valid=0, urgent_idx=0.
- Reset asserted mid-operation clears everything immediately, asynchronously.
- Sample on cycle N:
  - flag, state and new_need update at N+1;
  - urgent_idx/urgent_valid are valid in the same cycle as need_flags.
- Death detected on sample N: dead=1 and state=DEAD at N+1; urgent_valid=0 from N+1.
- ack on cycle N: flag low at N+1.
- revive on cycle N: state=ALIVE and need_flags=0 at N+1.
- new_need is high for exactly one cycle per sample that raises one or more flags. It is suppressed on the transition into DEAD.

## Configuration
- NEEDS_MONITOR_HYST_EN defined: clear threshold is WARN_LEVEL-HYST, so a level must drop HYST below WARN_LEVEL to clear a flag or mask.
- Not defined: clear threshold is WARN_LEVEL; HYST is unused.

## Structure
- Package needs_pkg holds:
  - the 2-bit state typedef: ST_ALIVE=0, ST_NEEDY=1, ST_DEAD=2;
  - need index constants: NEED_HUNGER=0, NEED_HAPPY=1, NEED_HEALTH=2, NEED_HYGIENE=3, NEED_ENERGY=4;
  - the default threshold constants.
- Sub-module need_channel holds one channel's count, flag and mask with threshold compare. It is generated NUM_NEEDS times; the FSM and priority encoder live in the top.

## Test plan
All scenarios use default parameters.
- Hunger=12 for 3 sample_en ticks → need_flags[0]=1 after the 3rd tick, new_need pulse, state=NEEDY, urgent_idx=0. After only 2 ticks then hunger=11 → no flag.
- Hygiene=13 and energy=14 flagged together → urgent_idx=3. Ack[3] → urgent_idx=4. Ack[4] → state=ALIVE.
- Ack[0] while hunger stays 13 → flag stays 0 across 5 ticks (masked). Hunger→9, then back to 12 for 3 ticks → flag re-sets.
- With NEEDS_MONITOR_HYST_EN: hunger flagged, then 11 → flag held; then 9 → flag cleared. Without the macro: 11 → flag cleared.
- Health=15 on a tick with ack[2] high → dead=1, need_flags=5'b11111, urgent_valid=0. Revive → ALIVE, flags=0. Health still 15 → DEAD again on the next tick.
- rst_n low mid-hold (count=2) → all outputs return to reset values at once. After release, 3 full ticks are needed to flag.
